// File: rtl/demux1_4_reg.sv
// Registered 1-to-4 demultiplexer with a valid/ready handshake and one holding register per channel.
// Optional per-channel output-transfer counters are built when DEMUX_CNT_EN is defined.
module demux1_4_reg #(
  parameter int bus_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [bus_width-1:0] d_i,
  input  logic [1:0]           s_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [bus_width-1:0] y0_o,
  output logic [bus_width-1:0] y1_o,
  output logic [bus_width-1:0] y2_o,
  output logic [bus_width-1:0] y3_o,
  output logic [3:0]           out_valid_o,
  input  logic [3:0]           out_ready_i
`ifdef DEMUX_CNT_EN
  ,
  output logic [31:0]          cnt_o
`endif
);

  logic [bus_width-1:0] y_q [4];
  logic [bus_width-1:0] y_d [4];
  logic [3:0]           valid_q;
  logic [3:0]           valid_d;
  logic                 in_ready_s;
  logic                 load_s;
  logic [3:0]           drain_s;

  // Accept unless the selected channel is occupied and its consumer is stalled.
  always_comb begin
    in_ready_s = 1'b0;
    case (s_i)
      2'd0:    in_ready_s = !valid_q[0] || out_ready_i[0];
      2'd1:    in_ready_s = !valid_q[1] || out_ready_i[1];
      2'd2:    in_ready_s = !valid_q[2] || out_ready_i[2];
      2'd3:    in_ready_s = !valid_q[3] || out_ready_i[3];
      default: in_ready_s = 1'b0;
    endcase
  end

  assign in_ready_o = in_ready_s;
  assign load_s     = in_valid_i && in_ready_s;
  assign drain_s    = valid_q & out_ready_i;

  // Per-channel next state: a load wins over a drain, so drain+refill keeps valid high.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      y_d[k]     = y_q[k];
      valid_d[k] = valid_q[k];
      if (load_s && (s_i == 2'(k))) begin
        y_d[k]     = d_i;
        valid_d[k] = 1'b1;
      end else if (drain_s[k]) begin
        valid_d[k] = 1'b0;
      end else begin
        valid_d[k] = valid_q[k];
      end
    end
  end

  // Holding registers and valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= '0;
      end
      valid_q <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= y_d[k];
      end
      valid_q <= valid_d;
    end
  end

  assign y0_o        = y_q[0];
  assign y1_o        = y_q[1];
  assign y2_o        = y_q[2];
  assign y3_o        = y_q[3];
  assign out_valid_o = valid_q;

`ifdef DEMUX_CNT_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  // Each counter advances (wrapping) on its channel's output transfer.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (drain_s[k]) begin
        cnt_d[k] = cnt_q[k] + 8'd1;
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign cnt_o = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux1_4_reg.sv
// Directed self-checking bench for demux1_4_reg; counter checks are built with DEMUX_CNT_EN.
module tb_demux1_4_reg;

  logic        clk;
  logic        rst_n;
  logic [15:0] d_i;
  logic [1:0]  s_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] y0_o, y1_o, y2_o, y3_o;
  logic [3:0]  out_valid_o;
  logic [3:0]  out_ready_i;
`ifdef DEMUX_CNT_EN
  logic [31:0] cnt_o;
`endif

  int checks_total;
  int checks_passed;

  demux1_4_reg #(.bus_width(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_i         (d_i),
    .s_i         (s_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .y0_o        (y0_o),
    .y1_o        (y1_o),
    .y2_o        (y2_o),
    .y3_o        (y3_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_o       (cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n       = 1'b0;
    d_i         = 16'h0000;
    s_i         = 2'd0;
    in_valid_i  = 1'b0;
    out_ready_i = 4'hF;
    #2;
    check_eq("rst_valid", {28'd0, out_valid_o}, 32'h0);
    check_eq("rst_y0", {16'd0, y0_o}, 32'h0);
    check_eq("rst_y3", {16'd0, y3_o}, 32'h0);
    check_eq("rst_in_ready", {31'd0, in_ready_o}, 32'h1);
    #10 rst_n = 1'b1;
    tick();

    // Routing to channel 2.
    s_i = 2'd2; d_i = 16'hA5A5; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check_eq("route_y2", {16'd0, y2_o}, 32'h0000A5A5);
    check_eq("route_valid", {28'd0, out_valid_o}, 32'h4);
    check_eq("route_y0", {16'd0, y0_o}, 32'h0);
    check_eq("route_y1", {16'd0, y1_o}, 32'h0);
    check_eq("route_y3", {16'd0, y3_o}, 32'h0);
    tick();
    check_eq("route_drained", {28'd0, out_valid_o}, 32'h0);
    check_eq("route_y2_hold", {16'd0, y2_o}, 32'h0000A5A5);

    // Back-to-back into channel 1.
    s_i = 2'd1; in_valid_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      d_i = 16'(i);
      #1;
      check_eq("b2b_in_ready", {31'd0, in_ready_o}, 32'h1);
      tick();
      check_eq("b2b_y1", {16'd0, y1_o}, 32'(i));
      check_eq("b2b_valid", {28'd0, out_valid_o}, 32'h2);
    end
    in_valid_i = 1'b0;
    tick();

    // Stall isolation: channel 0 stalled.
    out_ready_i = 4'b1110;
    s_i = 2'd0; d_i = 16'h0011; in_valid_i = 1'b1;
    tick();
    check_eq("stall_y0", {16'd0, y0_o}, 32'h0011);
    check_eq("stall_valid0", {28'd0, out_valid_o}, 32'h1);
    d_i = 16'hDEAD;
    #1;
    check_eq("stall_rdy_s0", {31'd0, in_ready_o}, 32'h0);
    tick();
    check_eq("stall_y0_kept", {16'd0, y0_o}, 32'h0011);
    s_i = 2'd3; d_i = 16'h3333;
    #1;
    check_eq("stall_rdy_s3", {31'd0, in_ready_o}, 32'h1);
    tick();
    in_valid_i = 1'b0;
    check_eq("stall_y3", {16'd0, y3_o}, 32'h3333);
    check_eq("stall_valid09", {28'd0, out_valid_o}, 32'h9);
    check_eq("stall_y0_hold", {16'd0, y0_o}, 32'h0011);
    tick();
    check_eq("stall_valid_after", {28'd0, out_valid_o}, 32'h1);
    out_ready_i = 4'hF;
    tick();
    check_eq("stall_release", {28'd0, out_valid_o}, 32'h0);

    // Drain and refill on channel 2 in the same cycle.
    out_ready_i = 4'b1011;
    s_i = 2'd2; d_i = 16'h1234; in_valid_i = 1'b1;
    tick();
    check_eq("refill_pre", {28'd0, out_valid_o}, 32'h4);
    out_ready_i = 4'hF; d_i = 16'h00FF;
    #1;
    check_eq("refill_rdy", {31'd0, in_ready_o}, 32'h1);
    tick();
    in_valid_i = 1'b0;
    check_eq("refill_y2", {16'd0, y2_o}, 32'h00FF);
    check_eq("refill_valid", {28'd0, out_valid_o}, 32'h4);
    tick();

    // Asynchronous reset with words pending on channels 1 and 3.
    out_ready_i = 4'h0;
    s_i = 2'd1; d_i = 16'h0101; in_valid_i = 1'b1;
    tick();
    s_i = 2'd3; d_i = 16'h0303;
    tick();
    in_valid_i = 1'b0;
    check_eq("arst_pre", {28'd0, out_valid_o}, 32'hA);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {28'd0, out_valid_o}, 32'h0);
    check_eq("arst_y1", {16'd0, y1_o}, 32'h0);
    check_eq("arst_y2", {16'd0, y2_o}, 32'h0);
    check_eq("arst_y3", {16'd0, y3_o}, 32'h0);
    #2 rst_n = 1'b1;
    out_ready_i = 4'hF;
    tick();

`ifdef DEMUX_CNT_EN
    // 257 output transfers on channel 3.
    check_eq("cnt_reset", cnt_o, 32'h0);
    s_i = 2'd3; in_valid_i = 1'b1;
    for (int i = 0; i < 257; i++) begin
      d_i = 16'(i);
      tick();
    end
    in_valid_i = 1'b0;
    tick();
    check_eq("cnt_ch3", {24'd0, cnt_o[31:24]}, 32'h1);
    check_eq("cnt_others", {8'd0, cnt_o[23:0]}, 32'h0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
